// File: rtl/mux_pkg.sv
// Shared types and constants for the 4-way 16-bit word mux and its round-robin front end.
package mux_pkg;

  localparam int unsigned N_WAY = 4;

  typedef logic [1:0] sel_t;

  localparam sel_t SEL_I0 = 2'd0;
  localparam sel_t SEL_I1 = 2'd1;
  localparam sel_t SEL_I2 = 2'd2;
  localparam sel_t SEL_I3 = 2'd3;

  // Output stage occupancy; the encoding doubles as o_valid.
  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } stage_t;

endpackage

// File: rtl/Mux4Way16.sv
// Plain 4-way 16-bit word multiplexer driven by a 2-bit select.
module Mux4Way16
  import mux_pkg::*;
(
  input  logic [15:0] a,
  input  logic [15:0] b,
  input  logic [15:0] c,
  input  logic [15:0] d,
  input  logic [1:0]  sel,
  output logic [15:0] out
);

  // Route the selected word to the output.
  always_comb begin
    out = '0;
    case (sel)
      SEL_I0:  out = a;
      SEL_I1:  out = b;
      SEL_I2:  out = c;
      SEL_I3:  out = d;
      default: out = '0;
    endcase
  end

endmodule

// File: rtl/rr_pick4.sv
// Combinational round-robin picker: first valid source after 'last', wrapping mod 4.
module rr_pick4
  import mux_pkg::*;
(
  input  logic [3:0] v,
  input  logic [1:0] last,
  output logic       grant_valid,
  output logic [1:0] sel
);

  sel_t idx;

  // Scan last+1 .. last+4 (the final step lands back on last itself).
  always_comb begin
    grant_valid = 1'b0;
    sel         = SEL_I0;
    idx         = SEL_I0;
    for (int unsigned k = 1; k <= N_WAY; k++) begin
      idx = last + sel_t'(k);
      if (!grant_valid && v[idx]) begin
        grant_valid = 1'b1;
        sel         = idx;
      end
    end
  end

endmodule

// File: rtl/rr_arbiter4_16.sv
// Round-robin arbiter over four valid/ready word sources feeding one registered
// valid/ready output stage through Mux4Way16.
module rr_arbiter4_16
  import mux_pkg::*;
#(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] i0,
  input  logic [WIDTH-1:0] i1,
  input  logic [WIDTH-1:0] i2,
  input  logic [WIDTH-1:0] i3,
  input  logic             v0,
  input  logic             v1,
  input  logic             v2,
  input  logic             v3,
  output logic             rdy0,
  output logic             rdy1,
  output logic             rdy2,
  output logic             rdy3,
  output logic [1:0]       sel,
  output logic [WIDTH-1:0] o,
  output logic             o_valid,
  input  logic             o_ready
);

  stage_t           state;
  stage_t           state_next;
  sel_t             last;
  sel_t             pick;
  logic             grant_valid;
  logic             accept;
  logic             load;
  logic [WIDTH-1:0] mux_out;

  rr_pick4 u_pick (
    .v           ({v3, v2, v1, v0}),
    .last        (last),
    .grant_valid (grant_valid),
    .sel         (pick)
  );

  Mux4Way16 u_mux (
    .a   (i0),
    .b   (i1),
    .c   (i2),
    .d   (i3),
    .sel (pick),
    .out (mux_out)
  );

  assign sel     = pick;
  assign o_valid = (state == FULL);

  // Handshake: stage can take a word when empty or being drained this cycle.
  always_comb begin
    accept = (state == EMPTY) || o_ready;
    load   = accept && grant_valid;
    rdy0   = rst_n && load && (pick == SEL_I0);
    rdy1   = rst_n && load && (pick == SEL_I1);
    rdy2   = rst_n && load && (pick == SEL_I2);
    rdy3   = rst_n && load && (pick == SEL_I3);
  end

  // Output stage next state: load wins over drain so it can refill while emptying.
  always_comb begin
    state_next = state;
    if (load) begin
      state_next = FULL;
    end else if ((state == FULL) && o_ready) begin
      state_next = EMPTY;
    end
  end

  // Output stage occupancy register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= EMPTY;
    end else begin
      state <= state_next;
    end
  end

  // Capture the granted word and advance the round-robin pointer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      o    <= '0;
      last <= SEL_I3;
    end else if (load) begin
      o    <= mux_out;
      last <= pick;
    end
  end

endmodule

// File: tb/tb_rr_arbiter4_16.sv
// Directed, table-driven bench for rr_arbiter4_16 with hand-computed expectations.
module tb_rr_arbiter4_16;

  logic        clk;
  logic        rst_n;
  logic [15:0] i0, i1, i2, i3;
  logic        v0, v1, v2, v3;
  logic        rdy0, rdy1, rdy2, rdy3;
  logic [1:0]  sel;
  logic [15:0] o;
  logic        o_valid;
  logic        o_ready;

  int unsigned errors;
  int unsigned checks;

  rr_arbiter4_16 #(.WIDTH(16)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .i0      (i0),
    .i1      (i1),
    .i2      (i2),
    .i3      (i3),
    .v0      (v0),
    .v1      (v1),
    .v2      (v2),
    .v3      (v3),
    .rdy0    (rdy0),
    .rdy1    (rdy1),
    .rdy2    (rdy2),
    .rdy3    (rdy3),
    .sel     (sel),
    .o       (o),
    .o_valid (o_valid),
    .o_ready (o_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  v;
    logic        ordy;
    logic [1:0]  exp_sel;
    logic [3:0]  exp_rdy;
    logic [15:0] exp_o;
    logic        exp_ov;
  } vec_t;

  vec_t vecs[14];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic set_v(input logic [3:0] v);
    {v3, v2, v1, v0} = v;
  endtask

  logic [15:0] rr_seq[5];

  initial begin
    errors = 0;
    checks = 0;
    i0 = 16'h1000; i1 = 16'h2000; i2 = 16'h4000; i3 = 16'h8000;

    // From reset (last=3, empty); data fixed as above.
    vecs[0]  = '{4'b0100, 1'b1, 2'd2, 4'b0100, 16'h4000, 1'b1};
    vecs[1]  = '{4'b1111, 1'b1, 2'd3, 4'b1000, 16'h8000, 1'b1};
    vecs[2]  = '{4'b1111, 1'b1, 2'd0, 4'b0001, 16'h1000, 1'b1};
    vecs[3]  = '{4'b1111, 1'b1, 2'd1, 4'b0010, 16'h2000, 1'b1};
    vecs[4]  = '{4'b1111, 1'b1, 2'd2, 4'b0100, 16'h4000, 1'b1};
    vecs[5]  = '{4'b1111, 1'b0, 2'd3, 4'b0000, 16'h4000, 1'b1};
    vecs[6]  = '{4'b1111, 1'b0, 2'd3, 4'b0000, 16'h4000, 1'b1};
    vecs[7]  = '{4'b1111, 1'b0, 2'd3, 4'b0000, 16'h4000, 1'b1};
    vecs[8]  = '{4'b1111, 1'b1, 2'd3, 4'b1000, 16'h8000, 1'b1};
    vecs[9]  = '{4'b1001, 1'b1, 2'd0, 4'b0001, 16'h1000, 1'b1};
    vecs[10] = '{4'b1001, 1'b1, 2'd3, 4'b1000, 16'h8000, 1'b1};
    vecs[11] = '{4'b0000, 1'b1, 2'd0, 4'b0000, 16'h8000, 1'b0};
    vecs[12] = '{4'b0000, 1'b0, 2'd0, 4'b0000, 16'h8000, 1'b0};
    vecs[13] = '{4'b0010, 1'b0, 2'd1, 4'b0010, 16'h2000, 1'b1};

    rr_seq[0] = 16'h1000; rr_seq[1] = 16'h2000; rr_seq[2] = 16'h4000;
    rr_seq[3] = 16'h8000; rr_seq[4] = 16'h1000;

    // Reset held with all sources valid: ready lines must still be low.
    rst_n   = 1'b0;
    o_ready = 1'b1;
    set_v(4'b1111);
    #2;
    check("reset_o", 32'(o), 32'h0);
    check("reset_ov", 32'(o_valid), 32'h0);
    check("reset_rdy", 32'({rdy3, rdy2, rdy1, rdy0}), 32'h0);
    set_v(4'b0000);
    @(posedge clk);
    #3;
    rst_n = 1'b1;

    for (int unsigned n = 0; n < 14; n++) begin
      set_v(vecs[n].v);
      o_ready = vecs[n].ordy;
      #1;
      check($sformatf("vec%0d_sel", n), 32'(sel), 32'(vecs[n].exp_sel));
      check($sformatf("vec%0d_rdy", n), 32'({rdy3, rdy2, rdy1, rdy0}), 32'(vecs[n].exp_rdy));
      @(posedge clk);
      #1;
      check($sformatf("vec%0d_o", n), 32'(o), 32'(vecs[n].exp_o));
      check($sformatf("vec%0d_ov", n), 32'(o_valid), 32'(vecs[n].exp_ov));
    end

    // Asynchronous reset between edges while full and with requests pending.
    set_v(4'b1111);
    o_ready = 1'b1;
    #2;
    rst_n = 1'b0;
    #1;
    check("async_rst_o", 32'(o), 32'h0);
    check("async_rst_ov", 32'(o_valid), 32'h0);
    check("async_rst_rdy", 32'({rdy3, rdy2, rdy1, rdy0}), 32'h0);
    #2;
    rst_n = 1'b1;

    // Full round robin from reset, one word per cycle.
    for (int unsigned n = 0; n < 5; n++) begin
      @(posedge clk);
      #1;
      check($sformatf("rr%0d_o", n), 32'(o), 32'(rr_seq[n]));
      check($sformatf("rr%0d_ov", n), 32'(o_valid), 32'h1);
    end

    // Reset mid-stream: word in flight dropped, restart from i0.
    #2;
    rst_n = 1'b0;
    #1;
    check("mid_rst_ov", 32'(o_valid), 32'h0);
    check("mid_rst_o", 32'(o), 32'h0);
    #2;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("mid_rst_first_o", 32'(o), 32'h1000);
    check("mid_rst_first_ov", 32'(o_valid), 32'h1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
